// File: rtl/sdram_funcmod_if.sv
// Call/response bundle between the SDRAM arbiter (master) and the command
// execution stage (slave).
interface sdram_funcmod_if;
    // Handshake: the master raises exactly the iCall bits it wants and holds
    // them, together with iAddr/iData, until it sees oDone high for one cycle.
    // It drops iCall on the cycle after oDone. The slave accepts a call only
    // while idle and latches iAddr/iData on the accepting edge. oData stays
    // valid from a read's oDone cycle until the next read completes.
    logic [3:0]  iCall;
    logic        oDone;
    logic [23:0] iAddr;
    logic [15:0] iData;
    logic [15:0] oData;

    modport master (output iCall, iAddr, iData, input oDone, oData);
    modport slave  (input iCall, iAddr, iData, output oDone, oData);
endinterface

// File: rtl/sdram_funcmod.sv
// SDRAM command-execution stage: turns one arbiter call into the pin-level
// command sequence (init, auto-refresh, single-word write or read).
module sdram_funcmod #(
    parameter logic [14:0] T_INIT = 15'd26600,
    parameter logic [3:0]  T_RP   = 4'd3,
    parameter logic [3:0]  T_RRC  = 4'd9,
    parameter logic [3:0]  T_MRD  = 4'd2,
    parameter logic [3:0]  T_RCD  = 4'd3,
    parameter logic [3:0]  T_WR   = 4'd2,
    parameter logic [3:0]  CL     = 4'd3,
    parameter logic [12:0] MODE   = 13'h030
) (
    input  logic          CLOCK,
    input  logic          RESET,
    sdram_funcmod_if.slave bus,
    output logic          S_CKE,
    output logic          S_NCS,
    output logic          S_NRAS,
    output logic          S_NCAS,
    output logic          S_NWE,
    output logic [1:0]    S_BA,
    output logic [12:0]   S_A,
    output logic [1:0]    S_DQM,
    inout  wire  [15:0]   S_DQ,
    output logic [3:0]    oDbgState,
    output logic          oDbgDqOe
);
    localparam logic [3:0] CMD_INH  = 4'b1111;
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_RD   = 4'b0101;
    localparam logic [3:0] CMD_WR   = 4'b0100;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_LMR  = 4'b0000;

    localparam logic [12:0] A_ALL_BANKS = 13'h0400;

    // Each wait ends when the counter (0 on the command cycle) reaches N-1,
    // so the following command lands exactly N cycles after the previous one.
    localparam logic [14:0] END_INIT = T_INIT - 15'd1;
    localparam logic [14:0] END_RP   = {11'd0, T_RP} - 15'd1;
    localparam logic [14:0] END_RRC  = {11'd0, T_RRC} - 15'd1;
    localparam logic [14:0] END_MRD  = {11'd0, T_MRD} - 15'd1;
    localparam logic [14:0] END_RCD  = {11'd0, T_RCD} - 15'd1;
    localparam logic [14:0] END_WRRP = {11'd0, T_WR} + {11'd0, T_RP} - 15'd1;
    localparam logic [14:0] END_CL   = {11'd0, CL} - 15'd1;
    localparam logic [14:0] END_RDRP = {11'd0, CL} + {11'd0, T_RP} - 15'd1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT_WAIT,
        ST_INIT_PRE,
        ST_INIT_REF1,
        ST_INIT_REF2,
        ST_INIT_LMR,
        ST_REF_PRE,
        ST_REF_AREF,
        ST_WR_ACT,
        ST_WRITE,
        ST_RD_ACT,
        ST_READ,
        ST_DONE,
        ST_RECOVER
    } stateType;

    stateType    state, nextState;
    logic [14:0] cnt, nextCnt;
    logic [3:0]  cmd, nextCmd;
    logic [1:0]  ba, nextBa;
    logic [12:0] addrPins, nextAddrPins;
    logic [1:0]  dqm, nextDqm;
    logic        dqOe, nextDqOe;
    logic        done, nextDone;
    logic [15:0] rdData, nextRdData;
    logic [1:0]  bankQ, nextBank;
    logic [8:0]  colQ, nextCol;
    logic [15:0] wordQ, nextWord;
    logic        cke;

    always_comb begin
        nextState    = state;
        nextCnt      = cnt + 15'd1;
        nextCmd      = CMD_NOP;
        nextBa       = ba;
        nextAddrPins = addrPins;
        nextDqm      = dqm;
        nextDqOe     = 1'b0;
        nextDone     = 1'b0;
        nextRdData   = rdData;
        nextBank     = bankQ;
        nextCol      = colQ;
        nextWord     = wordQ;

        case (state)
            ST_IDLE: begin
                nextCnt = '0;
                if (bus.iCall != 4'b0000) begin
                    nextBank = bus.iAddr[23:22];
                    nextCol  = bus.iAddr[8:0];
                    nextWord = bus.iData;
                end
                if (bus.iCall[0]) begin
                    nextState = ST_INIT_WAIT;
                end else if (bus.iCall[1]) begin
                    nextState    = ST_REF_PRE;
                    nextCmd      = CMD_PRE;
                    nextBa       = 2'b00;
                    nextAddrPins = A_ALL_BANKS;
                end else if (bus.iCall[3] || bus.iCall[2]) begin
                    // Write outranks read when both are requested.
                    nextState    = bus.iCall[3] ? ST_WR_ACT : ST_RD_ACT;
                    nextCmd      = CMD_ACT;
                    nextBa       = bus.iAddr[23:22];
                    nextAddrPins = bus.iAddr[21:9];
                end
            end
            ST_INIT_WAIT: begin
                if (cnt == END_INIT) begin
                    nextState    = ST_INIT_PRE;
                    nextCnt      = '0;
                    nextCmd      = CMD_PRE;
                    nextBa       = 2'b00;
                    nextAddrPins = A_ALL_BANKS;
                end
            end
            ST_INIT_PRE: begin
                if (cnt == END_RP) begin
                    nextState = ST_INIT_REF1;
                    nextCnt   = '0;
                    nextCmd   = CMD_AREF;
                end
            end
            ST_INIT_REF1: begin
                if (cnt == END_RRC) begin
                    nextState = ST_INIT_REF2;
                    nextCnt   = '0;
                    nextCmd   = CMD_AREF;
                end
            end
            ST_INIT_REF2: begin
                if (cnt == END_RRC) begin
                    nextState    = ST_INIT_LMR;
                    nextCnt      = '0;
                    nextCmd      = CMD_LMR;
                    nextBa       = 2'b00;
                    nextAddrPins = MODE;
                end
            end
            ST_INIT_LMR: begin
                // Byte masks open once the mode register is programmed.
                nextDqm = 2'b00;
                if (cnt == END_MRD) begin
                    nextState = ST_DONE;
                    nextCnt   = '0;
                    nextDone  = 1'b1;
                end
            end
            ST_REF_PRE: begin
                if (cnt == END_RP) begin
                    nextState = ST_REF_AREF;
                    nextCnt   = '0;
                    nextCmd   = CMD_AREF;
                end
            end
            ST_REF_AREF: begin
                if (cnt == END_RRC) begin
                    nextState = ST_DONE;
                    nextCnt   = '0;
                    nextDone  = 1'b1;
                end
            end
            ST_WR_ACT: begin
                if (cnt == END_RCD) begin
                    nextState    = ST_WRITE;
                    nextCnt      = '0;
                    nextCmd      = CMD_WR;
                    nextBa       = bankQ;
                    nextAddrPins = {4'b0010, colQ};
                    nextDqOe     = 1'b1;
                end
            end
            ST_WRITE: begin
                if (cnt == END_WRRP) begin
                    nextState = ST_DONE;
                    nextCnt   = '0;
                    nextDone  = 1'b1;
                end
            end
            ST_RD_ACT: begin
                if (cnt == END_RCD) begin
                    nextState    = ST_READ;
                    nextCnt      = '0;
                    nextCmd      = CMD_RD;
                    nextBa       = bankQ;
                    nextAddrPins = {4'b0010, colQ};
                end
            end
            ST_READ: begin
                if (cnt == END_CL) begin
                    nextRdData = S_DQ;
                end
                if (cnt == END_RDRP) begin
                    nextState = ST_DONE;
                    nextCnt   = '0;
                    nextDone  = 1'b1;
                end
            end
            ST_DONE: begin
                nextState = ST_RECOVER;
                nextCnt   = '0;
            end
            ST_RECOVER: begin
                // iCall is still high here; the arbiter drops it one cycle late.
                nextState = ST_IDLE;
                nextCnt   = '0;
            end
            default: begin
                nextState = ST_IDLE;
                nextCnt   = '0;
            end
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            cmd      <= CMD_INH;
            ba       <= 2'b00;
            addrPins <= '0;
            dqm      <= 2'b11;
            dqOe     <= 1'b0;
            done     <= 1'b0;
            rdData   <= '0;
            bankQ    <= 2'b00;
            colQ     <= '0;
            wordQ    <= '0;
            cke      <= 1'b1;
        end else begin
            state    <= nextState;
            cnt      <= nextCnt;
            cmd      <= nextCmd;
            ba       <= nextBa;
            addrPins <= nextAddrPins;
            dqm      <= nextDqm;
            dqOe     <= nextDqOe;
            done     <= nextDone;
            rdData   <= nextRdData;
            bankQ    <= nextBank;
            colQ     <= nextCol;
            wordQ    <= nextWord;
            cke      <= 1'b1;
        end
    end

    assign {S_NCS, S_NRAS, S_NCAS, S_NWE} = cmd;
    assign S_CKE     = cke;
    assign S_BA      = ba;
    assign S_A       = addrPins;
    assign S_DQM     = dqm;
    assign S_DQ      = dqOe ? wordQ : 16'hzzzz;
    assign bus.oDone = done;
    assign bus.oData = rdData;
    assign oDbgState = state;
    assign oDbgDqOe  = dqOe;
endmodule

// File: tb/tb_sdram_funcmod.sv
// Scoreboard bench for sdram_funcmod: expected pin events are queued per call,
// a negedge monitor pops and compares them; a small SDRAM model answers reads.
module tb_sdram_funcmod;
    localparam int T_INIT = 26600;
    localparam int T_RP   = 3;
    localparam int T_RRC  = 9;
    localparam int T_MRD  = 2;
    localparam int T_RCD  = 3;
    localparam int T_WR   = 2;
    localparam int CL     = 3;
    localparam logic [12:0] MODE = 13'h030;

    localparam logic [3:0] C_INH  = 4'b1111;
    localparam logic [3:0] C_NOP  = 4'b0111;
    localparam logic [3:0] C_ACT  = 4'b0011;
    localparam logic [3:0] C_RD   = 4'b0101;
    localparam logic [3:0] C_WR   = 4'b0100;
    localparam logic [3:0] C_PRE  = 4'b0010;
    localparam logic [3:0] C_AREF = 4'b0001;
    localparam logic [3:0] C_LMR  = 4'b0000;

    // Address check modes: none, A10 only, full BA+A. For done events 1 = check oData.
    localparam logic [1:0] AM_NONE = 2'd0;
    localparam logic [1:0] AM_A10  = 2'd1;
    localparam logic [1:0] AM_FULL = 2'd2;

    localparam int W = 54;

    // ---------------- clock / reset ----------------
    logic CLOCK = 1'b0;
    logic RESET = 1'b1;
    always #5 CLOCK = ~CLOCK;

    sdram_funcmod_if bus();
    logic        S_CKE, S_NCS, S_NRAS, S_NCAS, S_NWE;
    logic [1:0]  S_BA, S_DQM;
    logic [12:0] S_A;
    wire  [15:0] S_DQ;
    logic [3:0]  dbgState;
    logic        dbgDqOe;

    logic        memDrive = 1'b0;
    logic [15:0] rdWord   = 16'h0;
    assign S_DQ = memDrive ? rdWord : 16'hzzzz;

    sdram_funcmod dut (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .bus       (bus),
        .S_CKE     (S_CKE),
        .S_NCS     (S_NCS),
        .S_NRAS    (S_NRAS),
        .S_NCAS    (S_NCAS),
        .S_NWE     (S_NWE),
        .S_BA      (S_BA),
        .S_A       (S_A),
        .S_DQM     (S_DQM),
        .S_DQ      (S_DQ),
        .oDbgState (dbgState),
        .oDbgDqOe  (dbgDqOe)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    logic [15:0]  refMem [logic [23:0]];
    logic [23:0]  wrList[$];
    int checks   = 0;
    int failures = 0;
    int cycle    = 0;
    int lastEvt  = 0;
    logic [3:0] prevCall = 4'b0000;

    function automatic logic [3:0] pinCmd();
        return {S_NCS, S_NRAS, S_NCAS, S_NWE};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] mkEvt(input logic isDone, input int gap, input logic [3:0] c,
                                           input logic [1:0] am, input logic [1:0] ba,
                                           input logic [12:0] a, input logic [15:0] dat);
        logic [15:0] g;
        g = gap[15:0];
        return {isDone, g, c, am, ba, a, dat};
    endfunction

    // Reference model: what the pins must show for a call, from the command rules.
    task automatic pushExpected(input logic [3:0] call, input logic [23:0] addr, input logic [15:0] data);
        logic [1:0]  ba;
        logic [12:0] row;
        logic [12:0] colA;
        logic [15:0] rd;
        ba   = addr[23:22];
        row  = addr[21:9];
        colA = {4'b0010, addr[8:0]};
        if (call[0]) begin
            exp_q.push_back(mkEvt(1'b0, T_INIT + 1, C_PRE, AM_A10, 2'd0, 13'd0, 16'd0));
            exp_q.push_back(mkEvt(1'b0, T_RP, C_AREF, AM_NONE, 2'd0, 13'd0, 16'd0));
            exp_q.push_back(mkEvt(1'b0, T_RRC, C_AREF, AM_NONE, 2'd0, 13'd0, 16'd0));
            exp_q.push_back(mkEvt(1'b0, T_RRC, C_LMR, AM_FULL, 2'd0, MODE, 16'd0));
            exp_q.push_back(mkEvt(1'b1, T_MRD, C_NOP, AM_NONE, 2'd0, 13'd0, 16'd0));
        end else if (call[1]) begin
            exp_q.push_back(mkEvt(1'b0, 1, C_PRE, AM_A10, 2'd0, 13'd0, 16'd0));
            exp_q.push_back(mkEvt(1'b0, T_RP, C_AREF, AM_NONE, 2'd0, 13'd0, 16'd0));
            exp_q.push_back(mkEvt(1'b1, T_RRC, C_NOP, AM_NONE, 2'd0, 13'd0, 16'd0));
        end else if (call[3]) begin
            exp_q.push_back(mkEvt(1'b0, 1, C_ACT, AM_FULL, ba, row, 16'd0));
            exp_q.push_back(mkEvt(1'b0, T_RCD, C_WR, AM_FULL, ba, colA, data));
            exp_q.push_back(mkEvt(1'b1, T_WR + T_RP, C_NOP, AM_NONE, 2'd0, 13'd0, 16'd0));
            refMem[addr] = data;
            wrList.push_back(addr);
        end else if (call[2]) begin
            rd = refMem.exists(addr) ? refMem[addr] : 16'h0000;
            exp_q.push_back(mkEvt(1'b0, 1, C_ACT, AM_FULL, ba, row, 16'd0));
            exp_q.push_back(mkEvt(1'b0, T_RCD, C_RD, AM_FULL, ba, colA, 16'd0));
            exp_q.push_back(mkEvt(1'b1, CL + T_RP, C_NOP, AM_A10, 2'd0, 13'd0, rd));
        end
    endtask

    task automatic compareEvt(input logic isDone, input logic [3:0] c);
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event: got cmd=%b done=%b expected no event at t=%0t", c, isDone, $time);
        end else begin
            e = exp_q.pop_front();
            check("evt_kind", {31'd0, isDone}, {31'd0, e[53]});
            check("evt_gap", cycle - lastEvt, {16'd0, e[52:37]});
            if (!isDone) begin
                check("evt_cmd", {28'd0, c}, {28'd0, e[36:33]});
                check("cke", {31'd0, S_CKE}, 32'd1);
                if (e[32:31] == AM_A10) check("a10", {31'd0, S_A[10]}, 32'd1);
                if (e[32:31] == AM_FULL) begin
                    check("ba", {30'd0, S_BA}, {30'd0, e[30:29]});
                    check("addr", {19'd0, S_A}, {19'd0, e[28:16]});
                end
                if (e[36:33] == C_WR) begin
                    check("dq_oe_wr", {31'd0, dbgDqOe}, 32'd1);
                    check("dq_data", {16'd0, S_DQ}, {16'd0, e[15:0]});
                end
            end else if (e[32:31] == AM_A10) begin
                check("odata", {16'd0, bus.oData}, {16'd0, e[15:0]});
            end
        end
        lastEvt = cycle;
    endtask

    // ---------------- monitor ----------------
    always @(negedge CLOCK) begin
        logic [3:0] c;
        cycle++;
        if (!RESET) begin
            prevCall = 4'b0000;
            lastEvt  = cycle;
        end else begin
            c = pinCmd();
            if (prevCall == 4'b0000 && bus.iCall != 4'b0000) lastEvt = cycle;
            prevCall = bus.iCall;
            if (c != C_WR) check("dq_idle", {31'd0, dbgDqOe}, 32'd0);
            if (bus.oDone) compareEvt(1'b1, c);
            if (c != C_NOP && c != C_INH) compareEvt(1'b0, c);
        end
    end

    // ---------------- SDRAM model (CL=3) ----------------
    logic [15:0] sdMem [logic [23:0]];
    logic [12:0] openRow [4];
    int rdCnt = 0;
    always @(negedge CLOCK) begin
        logic [23:0] key;
        if (!RESET) begin
            memDrive = 1'b0;
            rdCnt    = 0;
        end else begin
            memDrive = (rdCnt == 1);
            if (rdCnt > 0) rdCnt--;
            key = {S_BA, openRow[S_BA], S_A[8:0]};
            case (pinCmd())
                C_ACT: openRow[S_BA] = S_A;
                C_WR:  sdMem[key] = S_DQ;
                C_RD: begin
                    rdWord = sdMem.exists(key) ? sdMem[key] : 16'h0000;
                    rdCnt  = 2;
                end
                default: ;
            endcase
        end
    end

    // ---------------- driver ----------------
    task automatic checkResetState(input string tag);
        check({tag, "_cmd"}, {28'd0, pinCmd()}, {28'd0, C_INH});
        check({tag, "_cke"}, {31'd0, S_CKE}, 32'd1);
        check({tag, "_ba"}, {30'd0, S_BA}, 32'd0);
        check({tag, "_a"}, {19'd0, S_A}, 32'd0);
        check({tag, "_dqm"}, {30'd0, S_DQM}, 32'd3);
        check({tag, "_dqoe"}, {31'd0, dbgDqOe}, 32'd0);
        check({tag, "_odata"}, {16'd0, bus.oData}, 32'd0);
        check({tag, "_odone"}, {31'd0, bus.oDone}, 32'd0);
    endtask

    task automatic doCall(input logic [3:0] call, input logic [23:0] addr, input logic [15:0] data);
        int budget;
        int n;
        logic gotDone;
        budget = call[0] ? 30000 : 60;
        pushExpected(call, addr, data);
        @(posedge CLOCK); #2;
        bus.iCall = call;
        bus.iAddr = addr;
        bus.iData = data;
        @(posedge CLOCK); #2;
        bus.iAddr = 24'($urandom);
        bus.iData = 16'($urandom);
        n = 0;
        gotDone = 1'b0;
        while (!gotDone && n < budget) begin
            @(negedge CLOCK);
            n++;
            gotDone = bus.oDone;
        end
        check("call_done", {31'd0, gotDone}, 32'd1);
        @(posedge CLOCK); #2;
        @(posedge CLOCK); #2;
        bus.iCall = 4'b0000;
    endtask

    initial begin
        int n;
        logic seen;
        bus.iCall = 4'b0000;
        bus.iAddr = 24'd0;
        bus.iData = 16'd0;
        #1 RESET = 1'b0;
        repeat (3) @(negedge CLOCK);
        checkResetState("rst");
        @(posedge CLOCK); #2 RESET = 1'b1;

        doCall(4'b0001, 24'd0, 16'd0);
        check("dqm_after_init", {30'd0, S_DQM}, 32'd0);
        doCall(4'b0010, 24'd0, 16'd0);
        doCall(4'b1000, 24'h40_1234, 16'hA55A);
        doCall(4'b0100, 24'h40_1234, 16'h0000);
        doCall(4'b1110, 24'h12_3456, 16'h7E7E);
        check("odata_hold", {16'd0, bus.oData}, 32'h0000_A55A);

        // Abort a write two cycles after its WR command.
        pushExpected(4'b1000, 24'h00_0100, 16'h1357);
        @(posedge CLOCK); #2;
        bus.iCall = 4'b1000;
        bus.iAddr = 24'h00_0100;
        bus.iData = 16'h1357;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 20) begin
            @(negedge CLOCK);
            n++;
            seen = (pinCmd() == C_WR);
        end
        check("wr_seen", {31'd0, seen}, 32'd1);
        @(negedge CLOCK);
        @(negedge CLOCK);
        #2 RESET = 1'b0;
        #1 checkResetState("midrst");
        exp_q.delete();
        bus.iCall = 4'b0000;
        repeat (2) @(negedge CLOCK);
        #2 RESET = 1'b1;

        doCall(4'b1000, 24'hFF_FFFF, 16'hC3C3);
        doCall(4'b0100, 24'hFF_FFFF, 16'h0000);

        for (int i = 0; i < 30; i++) begin
            int k;
            logic [3:0] c;
            logic [23:0] a;
            k = $urandom_range(0, 2);
            a = 24'($urandom);
            if (k == 0) begin
                c = 4'b0010 | {2'($urandom_range(0, 3)), 2'b00};
            end else if (k == 1) begin
                c = 4'b1000 | {1'b0, 1'($urandom_range(0, 1)), 2'b00};
            end else begin
                c = 4'b0100;
                if (wrList.size() > 0 && $urandom_range(0, 3) != 0)
                    a = wrList[$urandom_range(0, wrList.size() - 1)];
            end
            doCall(c, a, 16'($urandom));
        end

        repeat (5) @(negedge CLOCK);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sdram_funcmod.md
Name: sdram_funcmod

Overview:
Command-execution stage directly downstream of the SDRAM arbiter. It takes the arbiter's one-hot request vector (Write/Read/Auto-Refresh/Initial), runs the SDRAM pin-level command sequence with JEDEC timing, and returns a one-cycle done pulse. It drives the SDRAM pins and moves one 16-bit word per write or read access.

Parameters:
T_INIT, 15'd26600, power-up wait in clocks (200 us at 133 MHz)
T_RP, 4'd3, PRECHARGE to next command
T_RRC, 4'd9, AUTO REFRESH to next command
T_MRD, 4'd2, LOAD MODE to next command
T_RCD, 4'd3, ACTIVE to READ/WRITE
T_WR, 4'd2, write recovery before auto-precharge
CL, 4'd3, CAS latency; must match mode register bits A[6:4]
MODE, 13'h030, mode register value: burst length 1, sequential, CL=3, programmed write burst

Ports:
CLOCK  in  1  system clock, 133 MHz
RESET  in  1  asynchronous, active-low
iCall  in  4  [3]Write [2]Read [1]Refresh [0]Initial; level, held until oDone is seen
oDone  out 1  one-cycle completion pulse for the active call
iAddr  in  24  {BA[23:22], ROW[21:9], COL[8:0]}, sampled at sequence start
iData  in  16  write word, sampled at sequence start
oData  out 16  read word; valid from the oDone cycle until the next read completes
S_CKE  out 1  clock enable
S_NCS, S_NRAS, S_NCAS, S_NWE  out 1 each  command pins
S_BA  out 2  bank address
S_A  out 13  address
S_DQM  out 2  byte masks
S_DQ  inout 16  data bus, tri-stated unless writing

Behaviour:
- Command codes, as {NCS,NRAS,NCAS,NWE}: INH 1111, NOP 0111, ACT 0011, RD 0101, WR 0100, PRE 0010, AREF 0001, LMR 0000. All pin outputs are registered. Every command is held for exactly 1 cycle and is followed by NOPs during waits.
- Reset values: S_CKE=1, cmd=INH, S_BA=0, S_A=0, S_DQM=2'b11, DQ drive off, oData=0, oDone=0, FSM in IDLE, wait counter=0.
- Call selection in IDLE:
  - Priority when more than one bit is set: Initial > Refresh > Write > Read.
  - iCall=0 keeps the FSM in IDLE with NOP.
  - iAddr and iData are latched on the cycle the call is accepted.
- Initial sequence:
  - Wait T_INIT cycles.
  - PRE with A[10]=1, wait T_RP.
  - AREF, wait T_RRC. Repeat AREF, wait T_RRC.
  - LMR with S_A=MODE, S_BA=0, wait T_MRD.
  - S_DQM goes to 2'b00 after LMR and stays there.
  - Then DONE.
- Refresh sequence: PRE all (A[10]=1), wait T_RP, AREF, wait T_RRC, then DONE.
- Write sequence:
  - ACT with BA and ROW, wait T_RCD.
  - WR with A[10]=1 (auto-precharge), A[8:0]=COL.
  - S_DQ is driven with the latched iData during the WR cycle only.
  - Wait T_WR+T_RP, then DONE.
- Read sequence:
  - ACT, wait T_RCD.
  - RD with A[10]=1 and COL.
  - S_DQ is captured into oData on the edge CL cycles after the RD edge.
  - Wait T_RP more, then DONE.
- Waits: a "wait N" is N cycles counted from the command edge, so the next command issues N cycles after the previous one. The wait counter is 15 bits wide and cleared at each command.
- DONE state: oDone=1 for one cycle, then RECOVER for one cycle.
  - RECOVER ignores iCall, because the arbiter clears iCall only the cycle after it sees oDone.
  - Then IDLE.
- Requests outside Initial before Initial has completed are not guarded. The arbiter guarantees Initial comes first.
- Reset mid-operation: all outputs return to their reset values immediately. An in-flight access is abandoned and S_DQ is released at once.

Test Plan:
- Release reset, hold iCall=4'b0001 → INH/NOP for 26600 cycles, then PRE(A10=1), AREF 3 cycles later, AREF 9 cycles after that, LMR(S_A=13'h030) 9 cycles later, oDone pulse after T_MRD; S_DQM=00 afterwards.
- After init, iCall=4'b0010 → PRE, AREF 3 cycles later, oDone 9 cycles after AREF, exactly one cycle wide.
- Write iAddr=24'h40_1234, iData=16'hA55A → ACT with BA=1, ROW=13'h0009, COL=9'h034; WR 3 cycles later with A10=1; DQ driven A55A only in the WR cycle; oDone after the write-recovery and precharge wait.
- Read the same address against a CL=3 memory model → RD 3 cycles after ACT, oData=16'hA55A at the oDone cycle, DQ never driven by the DUT.
- iCall=4'b1110 in IDLE → Refresh executes first; iCall held during RECOVER starts no second sequence.
- Assert RESET 2 cycles after WR → cmd=INH, DQ released, oDone=0 immediately; iAddr=24'hFFFFFF afterwards → BA=3, ROW=13'h1FFF, COL=9'h1FF.
